// File: rtl/mem_bist_pkg.sv
// ---------------------------------------------------------------------------
// mem_bist_pkg
// Shared definitions for the memory BIST controller: FSM state encoding,
// default pattern constants and a reference pattern function for the default
// 16 x 8 geometry.
// ---------------------------------------------------------------------------
package mem_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR_A = 3'd1,
        ST_RD_A = 3'd2,
        ST_WR_B = 3'd3,
        ST_RD_B = 3'd4,
        ST_DONE = 3'd5
    } state_e;

    localparam int         DEF_DATA_W = 8;
    localparam int         DEF_ADDR_W = 4;
    localparam logic [7:0] DEF_SEED   = 8'hA5;
    localparam logic [7:0] DEF_STEP   = 8'h11;

    // Expected data for the default geometry: phase 0 = P(a), phase 1 = ~P(a).
    function automatic logic [DEF_DATA_W-1:0] pattern(input logic [DEF_ADDR_W-1:0] addr,
                                                      input logic                  phase);
        logic [DEF_DATA_W-1:0] p;
        p = DEF_SEED + DEF_DATA_W'(addr) * DEF_STEP;
        return phase ? ~p : p;
    endfunction

endpackage

// File: rtl/mem_bist_pattern.sv
// ---------------------------------------------------------------------------
// mem_bist_pattern
// Combinational BIST pattern generator: data = SEED + addr*STEP (mod 2**DATA_W),
// inverted when phase = 1.
// Ports:
//   addr   in  ADDR_W  location whose pattern is requested
//   phase  in  1       0 = true pattern, 1 = inverted pattern
//   data   out DATA_W  pattern word
// ---------------------------------------------------------------------------
module mem_bist_pattern
    import mem_bist_pkg::*;
#(
    parameter int                DATA_W = DEF_DATA_W,
    parameter int                ADDR_W = DEF_ADDR_W,
    parameter logic [DATA_W-1:0] SEED   = DATA_W'(DEF_SEED),
    parameter logic [DATA_W-1:0] STEP   = DATA_W'(DEF_STEP)
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic              phase,
    output logic [DATA_W-1:0] data
);

    logic [DATA_W-1:0] base;

    assign base = SEED + DATA_W'(addr) * STEP;
    assign data = phase ? ~base : base;

endmodule

// File: rtl/mem_bist_ctrl.sv
// ---------------------------------------------------------------------------
// mem_bist_ctrl
// March-style BIST initiator for an asynchronous-write, level-read memory.
// Writes P(a) to every location, reads back and compares, then repeats with
// ~P(a). Reports pass/fail, mismatch count and first failing address.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start                  run request (honoured only in IDLE/DONE)
//   busy, done, pass       run status; pass valid while done
//   err_count              mismatching reads in the current/last run
//   fail_valid, fail_addr  first mismatching address capture
//   mem_read, mem_write    memory strobes (registered, mutually exclusive)
//   mem_addr, mem_wdata    memory address / write data (registered)
//   mem_rdata              memory read data, combinational from mem_addr
// ---------------------------------------------------------------------------
module mem_bist_ctrl
    import mem_bist_pkg::*;
#(
    parameter int                DATA_W = DEF_DATA_W,
    parameter int                ADDR_W = DEF_ADDR_W,
    parameter logic [DATA_W-1:0] SEED   = DATA_W'(DEF_SEED),
    parameter logic [DATA_W-1:0] STEP   = DATA_W'(DEF_STEP)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W+1:0] err_count,
    output logic              fail_valid,
    output logic [ADDR_W-1:0] fail_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] exp_q;          // expected read data for the current cycle
    logic [ADDR_W+1:0] err_d;
    logic              fail_valid_d;
    logic [ADDR_W-1:0] fail_addr_d;
    logic              phase_d;
    logic              wr_d, rd_d;
    logic [DATA_W-1:0] pat_d;

    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        err_d        = err_count;
        fail_valid_d = fail_valid;
        fail_addr_d  = fail_addr;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d      = ST_WR_A;
                    cnt_d        = '0;
                    err_d        = '0;
                    fail_valid_d = 1'b0;
                    fail_addr_d  = '0;
                end
            end
            ST_WR_A, ST_WR_B: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ADDR)
                    state_d = (state_q == ST_WR_A) ? ST_RD_A : ST_RD_B;
            end
            ST_RD_A, ST_RD_B: begin
                if (mem_rdata != exp_q) begin
                    err_d = err_count + 1'b1;
                    if (!fail_valid) begin
                        fail_valid_d = 1'b1;
                        fail_addr_d  = cnt_q;
                    end
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ADDR)
                    state_d = (state_q == ST_RD_A) ? ST_WR_B : ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign phase_d = (state_d == ST_WR_B) || (state_d == ST_RD_B);
    assign wr_d    = (state_d == ST_WR_A) || (state_d == ST_WR_B);
    assign rd_d    = (state_d == ST_RD_A) || (state_d == ST_RD_B);

    // The generator looks one cycle ahead: its output is registered both as
    // the next write word and as the expected word for the next read cycle,
    // so a single instance serves write data and comparison.
    mem_bist_pattern #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .SEED   (SEED),
        .STEP   (STEP)
    ) u_pattern (
        .addr  (cnt_d),
        .phase (phase_d),
        .data  (pat_d)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            exp_q      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_addr  <= '0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            exp_q      <= pat_d;
            busy       <= wr_d || rd_d;
            done       <= (state_d == ST_DONE);
            pass       <= (state_d == ST_DONE) && (err_d == '0);
            err_count  <= err_d;
            fail_valid <= fail_valid_d;
            fail_addr  <= fail_addr_d;
            // Memory strobes come straight from flops: the write is
            // level-sensitive, so it must never glitch.
            mem_read   <= rd_d;
            mem_write  <= wr_d;
            mem_addr   <= (wr_d || rd_d) ? cnt_d : '0;
            mem_wdata  <= wr_d ? pat_d : '0;
        end
    end

endmodule

// File: tb/tb_mem_bist_ctrl.sv
module tb_mem_bist_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       busy, done, pass, fail_valid;
    logic [5:0] err_count;
    logic [3:0] fail_addr;
    logic       mem_read, mem_write;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;

    int n_pass  = 0;
    int n_total = 0;
    int viol    = 0;

    // Fault configuration of the memory model: 0 none, 1 stuck bit, 2 address alias
    int   f_kind = 0;
    int   f_addr = 0;
    int   f_bit  = 0;
    int   f_val  = 0;
    logic [7:0] mem [16];

    always #5 clk = ~clk;

    mem_bist_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_count  (err_count),
        .fail_valid (fail_valid),
        .fail_addr  (fail_addr),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    function automatic int phys(input int a);
        if (f_kind == 2) return a & ~(1 << f_bit);
        return a;
    endfunction

    function automatic logic [7:0] stored(input int idx, input logic [7:0] d);
        logic [7:0] m;
        m = 8'(1 << f_bit);
        if (f_kind == 1 && idx == f_addr) return (f_val != 0) ? (d | m) : (d & ~m);
        return d;
    endfunction

    function automatic logic [7:0] pat(input int a, input int ph);
        logic [7:0] p;
        p = 8'((165 + a * 17) % 256);
        return (ph != 0) ? ~p : p;
    endfunction

    // Memory: level write (stable for the whole cycle, committed mid-cycle), combinational read.
    always @(negedge clk)
        if (mem_write) mem[phys(int'(mem_addr))] = stored(phys(int'(mem_addr)), mem_wdata);

    always @* begin
        mem_rdata = 8'h00;
        if (mem_read) mem_rdata = mem[phys(int'(mem_addr))];
    end

    always @(negedge clk) begin
        if (mem_read && mem_write) viol++;
        if (!busy && mem_write) viol++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Behavioural reference: write all, read all, for both phases, through the faulty memory.
    task automatic ref_model(output int errs, output int faddr, output int fv);
        logic [7:0] m [16];
        errs = 0; faddr = 0; fv = 0;
        for (int ph = 0; ph < 2; ph++) begin
            for (int a = 0; a < 16; a++) m[phys(a)] = stored(phys(a), pat(a, ph));
            for (int a = 0; a < 16; a++)
                if (m[phys(a)] != pat(a, ph)) begin
                    errs++;
                    if (fv == 0) begin fv = 1; faddr = a; end
                end
        end
    endtask

    task automatic wait_done(inout int lat);
        while (!done && lat < 200) begin @(posedge clk); #1; lat++; end
    endtask

    // Start pulse, then run to completion; optional extra start pulse in cycle pulse_at.
    task automatic do_run(input int pulse_at, output int lat);
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0; lat = 1;
        while (!done && lat < 200) begin
            start = (lat == pulse_at);
            @(posedge clk); #1; lat++;
        end
        start = 1'b0;
    endtask

    task automatic check_result(input string tag, input int exp_err, input int exp_fa,
                                input int exp_fv);
        check({tag, " err_count"}, 64'(err_count), 64'(exp_err));
        check({tag, " fail_valid"}, 64'(fail_valid), 64'(exp_fv));
        check({tag, " fail_addr"}, 64'(fail_addr), 64'(exp_fa));
        check({tag, " pass"}, 64'(pass), 64'(exp_err == 0));
        check({tag, " busy"}, 64'(busy), 64'd0);
    endtask

    typedef struct {
        int kind; int addr; int bitn; int val;
        int exp_err; int exp_fa; int exp_fv;
    } vec_t;

    vec_t vecs [3];
    int lat, e_err, e_fa, e_fv, done_cycles;

    initial begin
        vecs[0] = '{kind: 0, addr: 0, bitn: 0, val: 0, exp_err: 0,  exp_fa: 0, exp_fv: 0};
        vecs[1] = '{kind: 1, addr: 5, bitn: 3, val: 0, exp_err: 1,  exp_fa: 5, exp_fv: 1};
        vecs[2] = '{kind: 2, addr: 0, bitn: 3, val: 0, exp_err: 16, exp_fa: 0, exp_fv: 1};

        rst_n = 1'b0; start = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        repeat (2) @(posedge clk); #1;
        check("reset status", 64'({busy, done, pass, fail_valid, err_count, fail_addr}), 64'd0);
        check("reset bus", 64'({mem_read, mem_write, mem_addr, mem_wdata}), 64'd0);
        @(negedge clk); rst_n = 1'b1;

        // Fault-free run with cycle-accurate write sequence check
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0; lat = 1;
        check("busy in cycle 1", 64'(busy), 64'd1);
        for (int a = 0; a < 16; a++) begin
            check($sformatf("write cycle addr %0d", a),
                  64'({mem_write, mem_read, mem_addr, mem_wdata}),
                  64'({1'b1, 1'b0, 4'(a), pat(a, 0)}));
            @(posedge clk); #1; lat++;
        end
        check("first read cycle", 64'({mem_write, mem_read, mem_addr, mem_wdata}),
              64'({1'b1 ^ 1'b1, 1'b1, 4'd0, 8'h00}));
        wait_done(lat);
        check("clean run latency", 64'(lat), 64'd65);
        check_result("clean", 0, 0, 0);
        check("idle bus", 64'({mem_read, mem_write, mem_addr, mem_wdata}), 64'd0);

        // Table-driven fault vectors
        foreach (vecs[i]) begin
            f_kind = vecs[i].kind; f_addr = vecs[i].addr;
            f_bit  = vecs[i].bitn; f_val  = vecs[i].val;
            do_run(0, lat);
            check($sformatf("vec%0d latency", i), 64'(lat), 64'd65);
            check_result($sformatf("vec%0d", i), vecs[i].exp_err, vecs[i].exp_fa, vecs[i].exp_fv);
        end
        f_kind = 0;

        // Reset in the middle of RD_A
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0; lat = 1;
        while (lat < 20) begin @(posedge clk); #1; lat++; end
        check("in read phase at cycle 20", 64'({mem_read, mem_write}), 64'b10);
        #2 rst_n = 1'b0;
        #1;
        check("async reset outputs", 64'({busy, done, pass, fail_valid, err_count, fail_addr,
              mem_read, mem_write, mem_addr, mem_wdata}), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        do_run(0, lat);
        check("rerun after reset latency", 64'(lat), 64'd65);
        check_result("rerun", 0, 0, 0);

        // start pulsed mid-run is ignored
        do_run(10, lat);
        check("start mid-run latency", 64'(lat), 64'd65);
        check_result("start mid-run", 0, 0, 0);
        @(posedge clk); #1;
        check("done held after run", 64'({done, busy}), 64'b10);

        // start held high: one-cycle done, immediate restart
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; lat = 1;
        wait_done(lat);
        check("held start latency", 64'(lat), 64'd65);
        check("held start pass", 64'(pass), 64'd1);
        done_cycles = 0;
        @(posedge clk); #1;
        check("held start done drops", 64'({done, busy}), 64'b01);
        check("restart write", 64'({mem_write, mem_addr, mem_wdata}), 64'({1'b1, 4'd0, 8'hA5}));
        start = 1'b0; lat = 1;
        wait_done(lat);
        check("second run latency", 64'(lat), 64'd65);
        check_result("second run", 0, 0, 0);

        // Randomised faults against the behavioural model
        for (int i = 0; i < 10; i++) begin
            f_kind = int'($urandom_range(0, 2));
            f_addr = int'($urandom_range(0, 15));
            f_bit  = (f_kind == 2) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 7));
            f_val  = int'($urandom_range(0, 1));
            ref_model(e_err, e_fa, e_fv);
            do_run(0, lat);
            check($sformatf("rand%0d latency", i), 64'(lat), 64'd65);
            check_result($sformatf("rand%0d k%0d a%0d b%0d v%0d", i, f_kind, f_addr, f_bit, f_val),
                         e_err, e_fa, e_fv);
        end

        check("bus exclusivity violations", 64'(viol), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_bist_ctrl.md
# mem_bist_ctrl

Built-in self-test initiator for the 16 x 8 asynchronous-write, level-read memory family (`read`/`write`/`addr`/`data_in`/`data_out` port set). On `start`, the block drives the memory's control side:
- writes a deterministic pattern to every location, then reads every location back and compares;
- repeats with the inverted pattern;
- reports pass/fail, an error count and the first failing address.

It sits between the test/boot sequencer and any memory instance with that port set, and is the only block driving the memory's inputs while `busy` is high.

## Interface
Parameters:
- `DATA_W`, 8, memory word width
- `ADDR_W`, 4, address width; depth = 2**ADDR_W
- `SEED`, 8'hA5, pattern base value
- `STEP`, 8'h11, pattern increment per address

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  request a test run; sampled only in IDLE or DONE
- `busy`  out  1  high while a run is in progress
- `done`  out  1  high from run completion until the next accepted `start`
- `pass`  out  1  valid when `done`; 1 = zero mismatches
- `err_count`  out  ADDR_W+2  mismatching reads in this run (max 2*depth = 32, never overflows)
- `fail_valid`  out  1  at least one mismatch captured
- `fail_addr`  out  ADDR_W  address of first mismatch
- `mem_read`  out  1  memory read enable
- `mem_write`  out  1  memory write enable
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory read data; combinational w.r.t. `mem_addr`/`mem_read`

## Operation
- Pattern: `P(a) = (SEED + a*STEP) mod 2**DATA_W`.
  - Phase A data = `P(a)`.
  - Phase B data = `~P(a)`.
- FSM states: IDLE, WR_A, RD_A, WR_B, RD_B, DONE.
- Transitions:
  - IDLE/DONE -> WR_A on `start`=1. Clears `err_count`, `fail_valid`, `fail_addr`, `pass`, `done`. Address counter = 0.
  - WR_x: `mem_write`=1, `mem_addr`=counter, `mem_wdata`=pattern. Counter increments each cycle. Leaves at counter = depth-1 for RD_x, with counter wrapping to 0.
  - RD_x: `mem_read`=1, `mem_addr`=counter. Each rising edge compares `mem_rdata` against expected `P(counter)` (A) or `~P(counter)` (B).
    - On mismatch: `err_count`+1.
    - If `fail_valid`=0: capture `fail_addr`=counter and set `fail_valid`=1.
  - RD_A at last address -> WR_B. RD_B at last address -> DONE.
- In DONE: `pass` = (`err_count`==0), `done`=1.
- `mem_read` and `mem_write` are never high in the same cycle. Both are 0 in IDLE and DONE.
- `mem_wdata` = 0 outside WR states. `mem_addr` = 0 in IDLE and DONE.
- `start` while busy is ignored.

## Timing
- Reset values, all outputs 0: `busy`, `done`, `pass`, `err_count`, `fail_valid`, `fail_addr`, `mem_read`, `mem_write`, `mem_addr`, `mem_wdata`. State = IDLE.
- All memory-side outputs are registered: no glitches on `mem_write`, which matters because the memory's write is level-sensitive.
- Start edge at cycle 0 -> `busy`=1 and first write (addr 0) visible in cycle 1.
- Run length: 4 x depth = 64 cycles. `done`=1 and `busy`=0 in cycle 65.
- Compare on the edge that ends each read cycle. The memory must settle `mem_rdata` within one clock period of the address change.
- Reset asserted mid-run:
  - all outputs drop immediately (asynchronously);
  - no further memory writes;
  - memory contents are undefined;
  - a new `start` reruns from WR_A.
- `start` held high continuously: one run, then in DONE immediate restart on the next edge. `done` is high for exactly one cycle in that case.

## Structure
- Shared package `mem_bist_pkg`:
  - state enum (6 states);
  - default `SEED`/`STEP` constants;
  - a function `pattern(addr, phase)` returning expected data.
- One natural sub-module, `mem_bist_pattern`: combinational pattern generator. Inputs: address and phase bit. Output: `DATA_W` data. Instantiated once and used for both write data and expected data.
- Counter, FSM and result registers live in the top module.

## Test plan
- Fault-free memory model, `start` pulse at cycle 0:
  - first write at cycle 1: addr 0, data A5; addr 1 = B6; addr 15 = A4;
  - cycle 65: `done`=1, `pass`=1, `err_count`=0, `fail_valid`=0.
- Memory with addr 5 bit 3 stuck-at-0:
  - P(5)=FA mismatches (reads F2); ~P=05 matches;
  - expect `err_count`=1, `fail_addr`=5, `pass`=0.
- Memory ignoring addr bit 3 (8..15 alias 0..7):
  - expect `err_count`=16, `fail_addr`=0, `fail_valid`=1, `pass`=0.
- Reset mid-run: `rst_n`=0 at cycle 20 (in RD_A):
  - all outputs 0 within the same cycle, including `mem_write`;
  - after release, `start` -> clean pass at +65 cycles.
- `start` pulsed at cycle 10 of a run: ignored, run still completes at cycle 65. `start` held high: `done` pulses for 1 cycle, second run begins with write addr 0, data A5.
- Bus exclusivity check throughout all above: `mem_read` & `mem_write` never both 1; `mem_write`=0 whenever `busy`=0.
